// File: rtl/xdma_irq_ctrl_regs_pkg.sv
// Shared constants for the XDMA user-interrupt control register block:
// register map, ID word, AXI response codes and FSM state encodings.
`ifndef XDMA_USR_INTR_COUNT
`define XDMA_USR_INTR_COUNT 7
`endif

package xdma_irq_ctrl_regs_pkg;

  localparam int INTR_COUNT_DEF = `XDMA_USR_INTR_COUNT;

  localparam logic [31:0] REG_STATUS   = 32'h000;
  localparam logic [31:0] REG_CLEAR    = 32'h004;
  localparam logic [31:0] REG_CNT_RST  = 32'h008;
  localparam logic [31:0] REG_ID       = 32'h00C;
  localparam logic [31:0] REG_CNT_BASE = 32'h100;

  localparam logic [31:0] ID_BASE = 32'h1A0C_0000;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  // addr is already word aligned; counter window holds one word per source
  function automatic logic addr_mapped(input logic [31:0] addr, input int n);
    return (addr == REG_STATUS) || (addr == REG_CLEAR) || (addr == REG_CNT_RST) ||
           (addr == REG_ID) ||
           ((addr >= REG_CNT_BASE) && (addr < REG_CNT_BASE + 32'(4 * n)));
  endfunction

endpackage

// File: rtl/xdma_irq_ctrl_regs_edge_counter.sv
// Per-source rising-edge event counter with synchronous clear.
module irq_edge_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             sys_rst_n,
  input  logic             req,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic prev;

  // A clear landing on the same cycle as an edge wins; the count wraps silently.
  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      prev <= 1'b0;
      cnt  <= '0;
    end else begin
      prev <= req;
      if (clr)
        cnt <= '0;
      else if (req && !prev)
        cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/xdma_irq_ctrl_regs.sv
// AXI4-Lite register block: interrupt status, W1C clear pulses toward the
// interrupt request module, and per-source rising-edge event counters.
module xdma_irq_ctrl_regs
  import xdma_irq_ctrl_regs_pkg::*;
#(
  parameter int INTR_COUNT = INTR_COUNT_DEF,
  parameter int ADDR_W     = 12,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  sys_rst_n,
  input  logic [ADDR_W-1:0]     s_axil_awaddr,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [31:0]           s_axil_wdata,
  input  logic [3:0]            s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_W-1:0]     s_axil_araddr,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [31:0]           s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  input  logic [INTR_COUNT-1:0] irq_req_in,
  output logic [INTR_COUNT-1:0] intr_clr,
  output logic [INTR_COUNT-1:0] intr_clr_vld
);

  wr_state_t wr_state, wr_state_next;
  rd_state_t rd_state, rd_state_next;

  logic                  aw_held, w_held, wstrb0_q;
  logic [31:0]           awaddr_q;
  logic [INTR_COUNT-1:0] wdata_q;
  logic                  aw_fire, w_fire, b_fire, ar_fire, r_fire, wr_commit;
  logic [31:0]           aw_aligned, ar_aligned, wr_addr;
  logic [INTR_COUNT-1:0] wr_data, clr_mask, cnt_rst_mask;
  logic                  wr_strb0;
  logic [31:0]           rd_data;
  logic [CNT_W-1:0]      cnt [INTR_COUNT];
  logic                  unused_bits;

  assign aw_aligned = 32'({s_axil_awaddr[ADDR_W-1:2], 2'b00});
  assign ar_aligned = 32'({s_axil_araddr[ADDR_W-1:2], 2'b00});
  assign aw_fire    = s_axil_awvalid && s_axil_awready;
  assign w_fire     = s_axil_wvalid && s_axil_wready;
  assign b_fire     = s_axil_bvalid && s_axil_bready;
  assign ar_fire    = s_axil_arvalid && s_axil_arready;
  assign r_fire     = s_axil_rvalid && s_axil_rready;
  assign unused_bits = ^{s_axil_wdata, s_axil_wstrb, s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  // A channel accepted this cycle bypasses its holding register.
  assign wr_addr  = aw_fire ? aw_aligned : awaddr_q;
  assign wr_data  = w_fire ? s_axil_wdata[INTR_COUNT-1:0] : wdata_q;
  assign wr_strb0 = w_fire ? s_axil_wstrb[0] : wstrb0_q;

  assign clr_mask     = (wr_commit && wr_strb0 && wr_addr == REG_CLEAR)   ? wr_data : '0;
  assign cnt_rst_mask = (wr_commit && wr_strb0 && wr_addr == REG_CNT_RST) ? wr_data : '0;

  always_comb begin
    wr_state_next = wr_state;
    wr_commit     = 1'b0;
    case (wr_state)
      WR_IDLE: if ((aw_held || aw_fire) && (w_held || w_fire)) begin
        wr_commit     = 1'b1;
        wr_state_next = WR_RESP;
      end
      WR_RESP: if (b_fire) wr_state_next = WR_IDLE;
      default: wr_state_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sys_rst_n) wr_state <= WR_IDLE;
    else            wr_state <= wr_state_next;
  end

  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      awaddr_q       <= '0;
      wdata_q        <= '0;
      wstrb0_q       <= 1'b0;
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_bvalid  <= 1'b0;
      s_axil_bresp   <= RESP_OKAY;
      intr_clr       <= '0;
      intr_clr_vld   <= '0;
    end else begin
      intr_clr     <= clr_mask;
      intr_clr_vld <= clr_mask;
      if (wr_commit) begin
        aw_held        <= 1'b0;
        w_held         <= 1'b0;
        s_axil_awready <= 1'b0;
        s_axil_wready  <= 1'b0;
        s_axil_bvalid  <= 1'b1;
        s_axil_bresp   <= addr_mapped(wr_addr, INTR_COUNT) ? RESP_OKAY : RESP_SLVERR;
      end else if (wr_state == WR_IDLE) begin
        if (aw_fire) begin
          aw_held  <= 1'b1;
          awaddr_q <= aw_aligned;
        end
        if (w_fire) begin
          w_held   <= 1'b1;
          wdata_q  <= s_axil_wdata[INTR_COUNT-1:0];
          wstrb0_q <= s_axil_wstrb[0];
        end
        s_axil_awready <= !(aw_held || aw_fire);
        s_axil_wready  <= !(w_held || w_fire);
      end else if (b_fire) begin
        s_axil_bvalid  <= 1'b0;
        s_axil_awready <= 1'b1;
        s_axil_wready  <= 1'b1;
      end
    end
  end

  // Write-only and unmapped words read as zero.
  always_comb begin
    rd_data = '0;
    if (ar_aligned == REG_STATUS) rd_data = 32'(irq_req_in);
    if (ar_aligned == REG_ID)     rd_data = ID_BASE | 32'(INTR_COUNT);
    for (int i = 0; i < INTR_COUNT; i++)
      if (ar_aligned == REG_CNT_BASE + 32'(4 * i)) rd_data = 32'(cnt[i]);
  end

  always_comb begin
    rd_state_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_fire) rd_state_next = RD_DATA;
      RD_DATA: if (r_fire)  rd_state_next = RD_IDLE;
      default: rd_state_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sys_rst_n) rd_state <= RD_IDLE;
    else            rd_state <= rd_state_next;
  end

  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b0;
      s_axil_rdata   <= '0;
      s_axil_rresp   <= RESP_OKAY;
    end else if (ar_fire) begin
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b1;
      s_axil_rdata   <= rd_data;
      s_axil_rresp   <= addr_mapped(ar_aligned, INTR_COUNT) ? RESP_OKAY : RESP_SLVERR;
    end else if (rd_state == RD_IDLE) begin
      s_axil_arready <= 1'b1;
    end else if (r_fire) begin
      s_axil_rvalid  <= 1'b0;
      s_axil_arready <= 1'b1;
    end
  end

  for (genvar i = 0; i < INTR_COUNT; i++) begin : gen_cnt
    irq_edge_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .sys_rst_n (sys_rst_n),
      .req       (irq_req_in[i]),
      .clr       (cnt_rst_mask[i]),
      .cnt       (cnt[i])
    );
  end

endmodule

// File: tb/tb_xdma_irq_ctrl_regs.sv
// Directed bench for xdma_irq_ctrl_regs: register map, W1C pulses, edge
// counters, error responses and mid-transaction reset.
module tb_xdma_irq_ctrl_regs;
  import xdma_irq_ctrl_regs_pkg::*;

  localparam int N = 7;

  logic          clk = 1'b0;
  logic          sys_rst_n;
  logic [11:0]   s_axil_awaddr, s_axil_araddr;
  logic          s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
  logic [31:0]   s_axil_wdata, s_axil_rdata;
  logic [3:0]    s_axil_wstrb;
  logic [1:0]    s_axil_bresp, s_axil_rresp;
  logic          s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
  logic          s_axil_rvalid, s_axil_rready;
  logic [N-1:0]  irq_req_in, intr_clr, intr_clr_vld;
  logic          wrap_req, wrap_clr;
  logic [3:0]    wrap_cnt;

  int            n_cmp = 0;
  int            n_fail = 0;
  int            pulse_cycles = 0;
  logic [N-1:0]  pulse_mask = '0;
  logic [N-1:0]  pulse_clr = '0;

  always #5 clk = ~clk;

  xdma_irq_ctrl_regs dut (
    .clk            (clk),
    .sys_rst_n      (sys_rst_n),
    .s_axil_awaddr  (s_axil_awaddr),
    .s_axil_awvalid (s_axil_awvalid),
    .s_axil_awready (s_axil_awready),
    .s_axil_wdata   (s_axil_wdata),
    .s_axil_wstrb   (s_axil_wstrb),
    .s_axil_wvalid  (s_axil_wvalid),
    .s_axil_wready  (s_axil_wready),
    .s_axil_bresp   (s_axil_bresp),
    .s_axil_bvalid  (s_axil_bvalid),
    .s_axil_bready  (s_axil_bready),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_arready (s_axil_arready),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rready  (s_axil_rready),
    .irq_req_in     (irq_req_in),
    .intr_clr       (intr_clr),
    .intr_clr_vld   (intr_clr_vld)
  );

  // Narrow stand-alone counter so the wrap boundary is reachable quickly.
  irq_edge_counter #(.CNT_W(4)) u_wrap (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .req       (wrap_req),
    .clr       (wrap_clr),
    .cnt       (wrap_cnt)
  );

  always @(negedge clk) begin
    if (intr_clr_vld != '0) begin
      pulse_cycles = pulse_cycles + 1;
      pulse_mask   = intr_clr_vld;
      pulse_clr    = intr_clr;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] vec);
    irq_req_in = vec;
  endtask

  task automatic checkPulse(input string tag, input int base, input int exp_cycles, input logic [N-1:0] exp_mask);
    #1;
    checkOutput({tag, "_cycles"}, 32'(pulse_cycles - base), 32'(exp_cycles));
    if (exp_cycles > 0) begin
      checkOutput({tag, "_vld"}, 32'(pulse_mask), 32'(exp_mask));
      checkOutput({tag, "_clr"}, 32'(pulse_clr), 32'(exp_mask));
    end
  endtask

  task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int w_delay, input int bready_delay, input bit skip_b,
                          output logic [1:0] resp);
    bit aw_done, w_done, aw_f, w_f, b_done;
    aw_done = 0; w_done = 0; b_done = 0; resp = 2'b11;
    s_axil_awaddr  = addr[11:0];
    s_axil_awvalid = 1'b1;
    s_axil_wdata   = data;
    s_axil_wstrb   = strb;
    for (int cyc = 0; cyc < 20 && !(aw_done && w_done); cyc++) begin
      if (cyc == w_delay) s_axil_wvalid = 1'b1;
      #1;
      aw_f = s_axil_awvalid && s_axil_awready;
      w_f  = s_axil_wvalid && s_axil_wready;
      @(negedge clk);
      if (aw_f) begin s_axil_awvalid = 1'b0; aw_done = 1; end
      if (w_f)  begin s_axil_wvalid  = 1'b0; w_done  = 1; end
    end
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    checkOutput("wr_accept", {30'd0, aw_done, w_done}, 32'd3);
    if (!skip_b) begin
      for (int i = 0; i < bready_delay; i++) begin
        checkOutput("bvalid_hold", 32'(s_axil_bvalid), 32'd1);
        @(negedge clk);
      end
      s_axil_bready = 1'b1;
      for (int cyc = 0; cyc < 20 && !b_done; cyc++) begin
        #1;
        if (s_axil_bvalid) begin b_done = 1; resp = s_axil_bresp; end
        @(negedge clk);
      end
      s_axil_bready = 1'b0;
      checkOutput("wr_b_beat", 32'(b_done), 32'd1);
    end
  endtask

  task automatic axiRead(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit ar_done, ar_f, r_done;
    ar_done = 0; r_done = 0; data = 32'hDEAD_BEEF; resp = 2'b11;
    s_axil_araddr  = addr[11:0];
    s_axil_arvalid = 1'b1;
    for (int cyc = 0; cyc < 20 && !ar_done; cyc++) begin
      #1;
      ar_f = s_axil_arvalid && s_axil_arready;
      @(negedge clk);
      if (ar_f) begin s_axil_arvalid = 1'b0; ar_done = 1; end
    end
    s_axil_arvalid = 1'b0;
    s_axil_rready  = 1'b1;
    for (int cyc = 0; cyc < 20 && !r_done; cyc++) begin
      #1;
      if (s_axil_rvalid) begin r_done = 1; data = s_axil_rdata; resp = s_axil_rresp; end
      @(negedge clk);
    end
    s_axil_rready = 1'b0;
    checkOutput("rd_accept", {30'd0, ar_done, r_done}, 32'd3);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rsp;
    int          p0;

    sys_rst_n = 1'b0;
    s_axil_awaddr = '0; s_axil_awvalid = 1'b0; s_axil_wdata = '0; s_axil_wstrb = '0;
    s_axil_wvalid = 1'b0; s_axil_bready = 1'b0; s_axil_araddr = '0; s_axil_arvalid = 1'b0;
    s_axil_rready = 1'b0; wrap_req = 1'b0; wrap_clr = 1'b0;
    applyStimulus('0);
    repeat (3) @(negedge clk);

    checkOutput("rst_awready", 32'(s_axil_awready), 0);
    checkOutput("rst_wready",  32'(s_axil_wready), 0);
    checkOutput("rst_bvalid",  32'(s_axil_bvalid), 0);
    checkOutput("rst_arready", 32'(s_axil_arready), 0);
    checkOutput("rst_rvalid",  32'(s_axil_rvalid), 0);
    checkOutput("rst_rdata",   s_axil_rdata, 0);
    checkOutput("rst_clr_vld", 32'(intr_clr_vld), 0);
    sys_rst_n = 1'b1;
    @(negedge clk);

    axiRead(REG_ID, rd, rsp);
    checkOutput("id_data", rd, 32'h1A0C_0007);
    checkOutput("id_resp", 32'(rsp), 0);
    axiRead(REG_STATUS, rd, rsp);
    checkOutput("status_zero", rd, 0);

    applyStimulus(7'b0100101);
    axiRead(REG_STATUS, rd, rsp);
    checkOutput("status_25", rd, 32'h25);

    p0 = pulse_cycles;
    axiWrite(REG_CLEAR, 32'h05, 4'hF, 1, 3, 0, rsp);
    checkOutput("clear_bresp", 32'(rsp), 0);
    checkPulse("clear_05", p0, 1, 7'h05);

    p0 = pulse_cycles;
    axiWrite(REG_CLEAR, 32'hFFFF_FF82, 4'h1, 0, 0, 0, rsp);
    checkPulse("clear_upper_ignored", p0, 1, 7'h02);

    p0 = pulse_cycles;
    axiWrite(REG_CLEAR, 32'h0, 4'hF, 0, 0, 0, rsp);
    checkPulse("clear_zero", p0, 0, '0);

    p0 = pulse_cycles;
    axiWrite(REG_CLEAR, 32'h7F, 4'b0000, 0, 0, 0, rsp);
    checkOutput("nostrb_bresp", 32'(rsp), 0);
    checkPulse("clear_nostrb", p0, 0, '0);

    axiRead(32'h200, rd, rsp);
    checkOutput("unmapped_rdata", rd, 0);
    checkOutput("unmapped_rresp", 32'(rsp), 32'(RESP_SLVERR));
    p0 = pulse_cycles;
    axiWrite(32'h010, 32'h7F, 4'hF, 0, 0, 0, rsp);
    checkOutput("unmapped_bresp", 32'(rsp), 32'(RESP_SLVERR));
    checkPulse("unmapped_wr", p0, 0, '0);

    applyStimulus('0);
    @(negedge clk);
    axiWrite(REG_CNT_RST, 32'h7F, 4'hF, 0, 0, 0, rsp);
    axiRead(REG_CNT_BASE, rd, rsp);
    checkOutput("cnt0_after_rst", rd, 0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(7'b1000000); @(negedge clk);
      applyStimulus('0);         @(negedge clk);
    end
    applyStimulus(7'b0000001);
    repeat (10) @(negedge clk);
    applyStimulus('0);
    @(negedge clk);
    axiRead(32'h118, rd, rsp);
    checkOutput("cnt6", rd, 3);
    axiRead(32'h100, rd, rsp);
    checkOutput("cnt0", rd, 1);
    axiRead(32'h104, rd, rsp);
    checkOutput("cnt1", rd, 0);

    applyStimulus(7'b0000100); @(negedge clk);
    applyStimulus('0);         @(negedge clk);
    axiRead(32'h108, rd, rsp);
    checkOutput("cnt2_one", rd, 1);
    // Edge on bit 2 lands in the same cycle the CNT_RST write commits.
    applyStimulus(7'b0000100);
    axiWrite(REG_CNT_RST, 32'h04, 4'hF, 0, 0, 0, rsp);
    axiRead(32'h108, rd, rsp);
    checkOutput("cnt2_rst_wins", rd, 0);
    axiRead(32'h118, rd, rsp);
    checkOutput("cnt6_untouched", rd, 3);
    applyStimulus('0);         @(negedge clk);
    applyStimulus(7'b0000100); @(negedge clk);
    axiRead(32'h108, rd, rsp);
    checkOutput("cnt2_resumes", rd, 1);
    applyStimulus('0);

    for (int i = 0; i < 15; i++) begin
      wrap_req = 1'b1; @(negedge clk);
      wrap_req = 1'b0; @(negedge clk);
    end
    checkOutput("wrap_all_ones", 32'(wrap_cnt), 32'hF);
    wrap_req = 1'b1; @(negedge clk);
    wrap_req = 1'b0; @(negedge clk);
    checkOutput("wrap_to_zero", 32'(wrap_cnt), 0);

    axiWrite(REG_CLEAR, 32'h10, 4'hF, 0, 0, 1, rsp);
    checkOutput("pre_rst_bvalid", 32'(s_axil_bvalid), 1);
    sys_rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_bvalid",  32'(s_axil_bvalid), 0);
    checkOutput("midrst_awready", 32'(s_axil_awready), 0);
    checkOutput("midrst_wready",  32'(s_axil_wready), 0);
    checkOutput("midrst_arready", 32'(s_axil_arready), 0);
    checkOutput("midrst_clr",     32'(intr_clr), 0);
    checkOutput("midrst_clr_vld", 32'(intr_clr_vld), 0);
    sys_rst_n = 1'b1;
    @(negedge clk);
    axiRead(32'h118, rd, rsp);
    checkOutput("cnt6_after_rst", rd, 0);
    p0 = pulse_cycles;
    axiWrite(REG_CLEAR, 32'h40, 4'hF, 1, 1, 0, rsp);
    checkOutput("post_rst_bresp", 32'(rsp), 0);
    checkPulse("post_rst_clear", p0, 1, 7'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
